// File: rtl/rv32_mem_arbiter_pkg.sv
// rtl/rv32_mem_arbiter_pkg.sv - shared types and request builders for the memory bus arbiter
package rv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  write_mask;
    logic [31:0] write_value;
  } bus_req_t;

  localparam int STARVE_W = 4;
  localparam int TIMER_W  = 8;

  function automatic bus_req_t instr_req(input logic [31:0] address);
    bus_req_t r;
    r         = '0;
    r.read    = 1'b1;
    r.address = address;
    return r;
  endfunction

  // Simultaneous read+write is resolved as a write; reads carry no byte enables or data.
  function automatic bus_req_t data_req(input logic        is_write,
                                        input logic [31:0] address,
                                        input logic [3:0]  write_mask,
                                        input logic [31:0] write_value);
    bus_req_t r;
    r         = '0;
    r.read    = ~is_write;
    r.write   = is_write;
    r.address = address;
    if (is_write) begin
      r.write_mask  = write_mask;
      r.write_value = write_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_bus_timer.sv
// rtl/rv32_bus_timer.sv - loadable saturating down-counter flagging a bus access timeout
module rv32_bus_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - fetch/data arbiter for one external memory bus with starvation guard and timeout
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic        instr_ready_out,
  output logic [31:0] instr_read_value_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [31:0] data_address_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic        data_ready_out,
  output logic [31:0] data_read_value_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [31:0] bus_address_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic        bus_fault_out
);

  localparam logic [STARVE_W-1:0] STARVE_MAX   = STARVE_W'(STARVE_LIMIT);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LOAD = TIMER_W'(TIMEOUT - 1);

  arb_state_e            state, next_state;
  owner_e                owner;
  bus_req_t              bus_q, bus_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;

  logic busy, fault, done, arbitrate;
  logic instr_pend, data_pend, fetch_forced;
  logic grant_instr, grant_data;
  logic timer_expired;

  always_comb begin
    owner = OWN_NONE;
    unique case (state)
      ST_INSTR: owner = OWN_INSTR;
      ST_DATA:  owner = OWN_DATA;
      default:  owner = OWN_NONE;
    endcase
  end

  assign busy  = (state != ST_IDLE);
  assign fault = busy && !bus_ready_in && timer_expired;
  assign done  = busy && (bus_ready_in || fault);

  // The requester finishing this cycle is still holding its request; keep it out of the next grant.
  assign instr_pend   = instr_read_in && !(done && (owner == OWN_INSTR));
  assign data_pend    = (data_read_in || data_write_in) && !(done && (owner == OWN_DATA));
  assign arbitrate    = !busy || done;
  assign fetch_forced = instr_pend && (starve_q == STARVE_MAX);
  assign grant_data   = arbitrate && data_pend && !fetch_forced;
  assign grant_instr  = arbitrate && instr_pend && !grant_data;

  always_comb begin
    next_state = state;
    bus_d      = bus_q;
    starve_d   = starve_q;
    if (arbitrate) begin
      next_state = ST_IDLE;
      bus_d      = '0;
      if (grant_data) begin
        next_state = ST_DATA;
        bus_d      = data_req(data_write_in, data_address_in,
                              data_write_mask_in, data_write_value_in);
        if (instr_read_in) begin
          starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end else begin
          starve_d = '0;
        end
      end else if (grant_instr) begin
        next_state = ST_INSTR;
        bus_d      = instr_req(instr_address_in);
        starve_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bus_q    <= '0;
      starve_q <= '0;
    end else begin
      state    <= next_state;
      bus_q    <= bus_d;
      starve_q <= starve_d;
    end
  end

  rv32_bus_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (grant_data || grant_instr),
    .load_value (TIMEOUT_LOAD),
    .dec        (busy && !bus_ready_in),
    .expired    (timer_expired)
  );

  // An aborted access completes with zero data; writes never return data.
  always_comb begin
    instr_ready_out      = done && (owner == OWN_INSTR);
    data_ready_out       = done && (owner == OWN_DATA);
    instr_read_value_out = '0;
    data_read_value_out  = '0;
    if (instr_ready_out && bus_ready_in) begin
      instr_read_value_out = bus_read_value_in;
    end
    if (data_ready_out && bus_ready_in && !bus_q.write) begin
      data_read_value_out = bus_read_value_in;
    end
  end

  assign bus_read_out        = bus_q.read;
  assign bus_write_out       = bus_q.write;
  assign bus_address_out     = bus_q.address;
  assign bus_write_mask_out  = bus_q.write_mask;
  assign bus_write_value_out = bus_q.write_value;
  assign bus_fault_out       = fault;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - self-checking bench for rv32_mem_arbiter
module tb_rv32_mem_arbiter;

  localparam int STARVE_LIMIT = 1;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic        instr_ready_out;
  logic [31:0] instr_read_value_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [31:0] data_address_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic        data_ready_out;
  logic [31:0] data_read_value_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [31:0] bus_address_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        bus_fault_out;

  int errors = 0;
  int checks = 0;

  logic [104:0] obs;
  logic [104:0] exp;

  always #5 clk = ~clk;

  assign obs = {bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out,
                instr_ready_out, instr_read_value_out,
                data_ready_out, data_read_value_out, bus_fault_out};

  rv32_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_read_in        (instr_read_in),
    .instr_address_in     (instr_address_in),
    .instr_ready_out      (instr_ready_out),
    .instr_read_value_out (instr_read_value_out),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_address_in      (data_address_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_ready_out       (data_ready_out),
    .data_read_value_out  (data_read_value_out),
    .bus_read_out         (bus_read_out),
    .bus_write_out        (bus_write_out),
    .bus_address_out      (bus_address_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (bus_read_value_in),
    .bus_ready_in         (bus_ready_in),
    .bus_fault_out        (bus_fault_out)
  );

  task automatic clear_inputs;
    instr_read_in       = 1'b0;
    instr_address_in    = '0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_address_in     = '0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    bus_read_value_in   = '0;
    bus_ready_in        = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({obs, bus_write_value_out} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h/%h exp=0", obs, bus_write_value_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_single;
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h100;
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_req_cycle got=%h exp=%h", obs, exp); end
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h13;
    #1; exp = {1'b1, 1'b0, 32'h100, 4'h0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_complete got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_back_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h200;
    data_read_in  = 1'b1; data_address_in  = 32'h8000;
    #1;
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'hAAAA5555;
    #1; exp = {1'b1, 1'b0, 32'h8000, 4'h0, 1'b0, 32'h0, 1'b1, 32'hAAAA5555, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_data_first got=%h exp=%h", obs, exp); end
    @(negedge clk);
    data_read_in = 1'b0; bus_read_value_in = 32'h13579BDF;
    #1; exp = {1'b1, 1'b0, 32'h200, 4'h0, 1'b1, 32'h13579BDF, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_fetch_next got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_starvation;
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h300;
    @(negedge clk);
    data_read_in = 1'b1; data_address_in = 32'h9000;
    bus_ready_in = 1'b1; bus_read_value_in = 32'h11;
    #1; exp = {1'b1, 1'b0, 32'h300, 4'h0, 1'b1, 32'h11, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_fetch0 got=%h exp=%h", obs, exp); end
    // data grant taken while fetch was still asserted: one starved grant
    @(negedge clk);
    instr_read_in = 1'b0; bus_read_value_in = 32'h22;
    #1; exp = {1'b1, 1'b0, 32'h9000, 4'h0, 1'b0, 32'h0, 1'b1, 32'h22, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_data1 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h400;
    data_address_in = 32'hA000; bus_ready_in = 1'b0;
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_idle got=%h exp=%h", obs, exp); end
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h44;
    #1; exp = {1'b1, 1'b0, 32'h400, 4'h0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_fetch_forced got=%h exp=%h", obs, exp); end
    @(negedge clk);
    instr_read_in = 1'b0; bus_read_value_in = 32'h55;
    #1; exp = {1'b1, 1'b0, 32'hA000, 4'h0, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_data_after got=%h exp=%h", obs, exp); end
    @(negedge clk);
    data_address_in = 32'hB000; bus_ready_in = 1'b0;
    #1;
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h66;
    #1; exp = {1'b1, 1'b0, 32'hB000, 4'h0, 1'b0, 32'h0, 1'b1, 32'h66, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_data_alone got=%h exp=%h", obs, exp); end
    // counter was cleared by the lone data grant, so data wins again
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h600;
    data_address_in = 32'hC000; bus_ready_in = 1'b0;
    #1;
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h77;
    #1; exp = {1'b1, 1'b0, 32'hC000, 4'h0, 1'b0, 32'h0, 1'b1, 32'h77, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_cleared got=%h exp=%h", obs, exp); end
    @(negedge clk);
    data_read_in = 1'b0; bus_read_value_in = 32'h88;
    #1; exp = {1'b1, 1'b0, 32'h600, 4'h0, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL starve_final_fetch got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_write_wait;
    @(negedge clk);
    data_write_in = 1'b1; data_read_in = 1'b1; data_address_in = 32'h1004;
    data_write_mask_in = 4'b0011; data_write_value_in = 32'hDEADBEEF;
    bus_read_value_in = 32'h12345678;
    #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus_ready_in = (k == 4);
      #1;
      exp = {1'b0, 1'b1, 32'h1004, 4'h3, 1'b0, 32'h0, (k == 4), 32'h0, 1'b0};
      checks++;
      if (obs !== exp || bus_write_value_out !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_wait_cycle%0d got=%h/%h exp=%h/deadbeef", k, obs, bus_write_value_out, exp);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL write_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_timeout;
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h500; bus_read_value_in = 32'hFFFFFFFF;
    #1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      #1;
      exp = {1'b1, 1'b0, 32'h500, 4'h0, (k == TIMEOUT), 32'h0, 1'b0, 32'h0, (k == TIMEOUT)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL timeout_cycle%0d got=%h exp=%h", k, obs, exp); end
    end
    @(negedge clk);
    instr_read_in = 1'b0;
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL timeout_strobe_drop got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    data_read_in = 1'b1; data_address_in = 32'h7000;
    #1;
    @(negedge clk);
    #1; exp = {1'b1, 1'b0, 32'h7000, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_pre got=%h exp=%h", obs, exp); end
    #2;
    reset_n = 1'b0; bus_ready_in = 1'b1; bus_read_value_in = 32'h5A5A5A5A;
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_async got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    instr_read_in = 1'b1; instr_address_in = 32'h800;
    #1; exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_idle got=%h exp=%h", obs, exp); end
    @(negedge clk);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h99;
    #1; exp = {1'b1, 1'b0, 32'h800, 4'h0, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_regrant got=%h exp=%h", obs, exp); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_random;
    int          m_owner, m_starve, m_wait;
    logic        m_read, m_write;
    logic [31:0] m_addr, m_wval;
    logic [3:0]  m_mask;
    logic        i_act, d_act, d_rd, d_wr, stall;
    logic [31:0] i_addr, d_addr, d_wval;
    logic [3:0]  d_mask;
    logic        prev_ir, prev_dr;
    logic        e_fault, e_done, e_ir, e_dr, ip, dp;
    logic [31:0] e_iv, e_dv;
    int          sel;

    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 0; m_starve = 0; m_wait = 0;
    m_read = 0; m_write = 0; m_addr = 0; m_mask = 0; m_wval = 0;
    i_act = 0; d_act = 0; d_rd = 0; d_wr = 0; stall = 0;
    i_addr = 0; d_addr = 0; d_wval = 0; d_mask = 0;
    prev_ir = 0; prev_dr = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (prev_ir) i_act = 0;
      if (prev_dr) d_act = 0;
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_addr = $urandom; d_mask = 4'($urandom); d_wval = $urandom;
        sel = $urandom_range(0, 2);
        d_rd = (sel != 1); d_wr = (sel != 0);
      end
      if ($urandom_range(0, 39) == 0) stall = ~stall;
      instr_read_in       = i_act;
      instr_address_in    = i_addr;
      data_read_in        = d_act && d_rd;
      data_write_in       = d_act && d_wr;
      data_address_in     = d_addr;
      data_write_mask_in  = d_mask;
      data_write_value_in = d_wval;
      bus_ready_in        = stall ? 1'b0 : ($urandom_range(0, 1) == 1);
      bus_read_value_in   = $urandom;
      #1;

      e_fault = (m_owner != 0) && !bus_ready_in && (m_wait == TIMEOUT - 1);
      e_done  = (m_owner != 0) && (bus_ready_in || e_fault);
      e_ir    = e_done && (m_owner == 1);
      e_dr    = e_done && (m_owner == 2);
      e_iv    = (e_ir && bus_ready_in) ? bus_read_value_in : 32'h0;
      e_dv    = (e_dr && bus_ready_in && !m_write) ? bus_read_value_in : 32'h0;
      exp = {m_read, m_write, m_addr, m_mask, e_ir, e_iv, e_dr, e_dv, e_fault};
      checks++;
      if (obs !== exp || (m_write && bus_write_value_out !== m_wval)) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h/%h exp=%h/%h", cyc, obs, bus_write_value_out, exp, m_wval);
      end
      prev_ir = e_ir;
      prev_dr = e_dr;

      if (m_owner == 0 || e_done) begin
        ip = instr_read_in && !(e_done && m_owner == 1);
        dp = (data_read_in || data_write_in) && !(e_done && m_owner == 2);
        m_wait = 0;
        if (dp && !(ip && m_starve == STARVE_LIMIT)) begin
          m_owner = 2;
          m_write = data_write_in; m_read = !data_write_in; m_addr = data_address_in;
          m_mask  = data_write_in ? data_write_mask_in : 4'h0;
          m_wval  = data_write_value_in;
          m_starve = !instr_read_in ? 0 : (m_starve < STARVE_LIMIT ? m_starve + 1 : m_starve);
        end else if (ip) begin
          m_owner = 1;
          m_read = 1; m_write = 0; m_addr = instr_address_in; m_mask = 4'h0;
          m_starve = 0;
        end else begin
          m_owner = 0;
          m_read = 0; m_write = 0; m_addr = 0; m_mask = 0;
        end
      end else begin
        m_wait++;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_single();
    test_back_to_back();
    test_starvation();
    test_write_wait();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
